// File: rtl/rr_arbiter_onehot_if.sv
// rtl/rr_arbiter_onehot_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Purpose: groups the request vector, grant acknowledge and registered grant
// outputs of rr_arbiter_onehot into one connection.
// Signals:
//   reqIn      [N-1:0]  request vector, bit i = requester i wants the resource
//   grantAck            consumer accepts the current grant
//   grantOut   [N-1:0]  registered grant, zero or exactly one bit set
//   grantValid          high exactly when grantOut is non-zero
// Modports:
//   master  requester/consumer side (drives reqIn, grantAck)
//   slave   arbiter side (drives grantOut, grantValid)
interface rr_arbiter_onehot_if #(
  parameter int N = 16
);
  logic [N-1:0] reqIn;
  logic         grantAck;
  logic [N-1:0] grantOut;
  logic         grantValid;

  modport master (
    output reqIn,
    output grantAck,
    input  grantOut,
    input  grantValid
  );

  modport slave (
    input  reqIn,
    input  grantAck,
    output grantOut,
    output grantValid
  );
endinterface

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - round-robin arbiter with registered one-hot grant held until acknowledged
//
// Purpose: picks one of N requesters in round-robin order and presents a
// registered one-hot grant that stays put until the consumer acknowledges it.
// On acknowledge the just-served requester drops to lowest priority and the
// same edge re-arbitrates, so back-to-back grants have no idle bubble.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears grant and pointer)
//   bus    rr_arbiter_onehot_if.slave: reqIn, grantAck in; grantOut, grantValid out
module rr_arbiter_onehot #(
  parameter int N  = 16,
  parameter int PW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_arbiter_onehot_if.slave    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [N-1:0]    grant_q;
  logic [N-1:0]    grant_d;

  logic [PW-1:0]   granted_idx;
  logic            accepted;
  logic [PW-1:0]   search_base;
  logic [PW-1:0]   scan_idx;
  logic            found;
  logic [N-1:0]    winner;
  logic            any_req;

  // Binary index of the currently held grant (grant_q is one-hot or zero).
  always_comb begin
    granted_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        granted_idx = PW'(i);
      end
    end
  end

  // An acknowledged grant moves the search start past the served requester in
  // the same cycle, so re-arbitration already sees the rotated priority.
  // N is a power of two, so the PW-bit add wraps modulo N for free.
  assign accepted    = (state_q == GRANT) && bus.grantAck;
  assign search_base = accepted ? (granted_idx + PW'(1)) : ptr_q;
  assign any_req     = |bus.reqIn;

  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = search_base + PW'(k);
      if (!found && bus.reqIn[scan_idx]) begin
        winner[scan_idx] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        // Arbitration from idle does not touch the pointer.
        if (any_req) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Without an acknowledge the grant is held, even if its request drops.
        if (bus.grantAck) begin
          ptr_d   = search_base;
          grant_d = winner;
          state_d = any_req ? GRANT : IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grantOut   = grant_q;
  assign bus.grantValid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// tb/tb_rr_arbiter_onehot.sv - self-checking bench for rr_arbiter_onehot against a round-robin reference model
module tb_rr_arbiter_onehot;

  localparam int N = 16;

  logic clk;
  logic rst_n;

  rr_arbiter_onehot_if #(.N(N)) bus ();

  rr_arbiter_onehot #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: index of held grant (-1 = none) and priority start.
  int m_gidx = -1;
  int m_ptr  = 0;

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_gidx >= 0) g[m_gidx] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic ack);
    int win;
    if (m_gidx >= 0 && !ack) return;
    if (m_gidx >= 0) m_ptr = (m_gidx + 1) % N;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    m_gidx = win;
  endtask

  // Advance one clock: model sees the inputs held across the edge; outputs are
  // then available for comparison at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(bus.reqIn, bus.grantAck);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.reqIn    = '0;
    bus.grantAck = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    m_gidx = -1;
    m_ptr  = 0;
    rst_n  = 1'b1;
  endtask

  // Structural invariant on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (!$onehot0(bus.grantOut) || (bus.grantValid !== (|bus.grantOut)))
        $display("FAIL invariant: grantOut=%h grantValid=%b", bus.grantOut, bus.grantValid);
      else
        passed++;
    end
  end

  task automatic test_reset();
    bus.reqIn    = '0;
    bus.grantAck = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.grantOut !== 16'h0000 || bus.grantValid !== 1'b0)
      $display("FAIL reset: grantOut=%h valid=%b want 0000/0", bus.grantOut, bus.grantValid);
    else passed++;
    m_gidx = -1;
    m_ptr  = 0;
    rst_n  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (bus.grantOut !== 16'h0000 || bus.grantValid !== 1'b0)
        $display("FAIL idle_after_reset: cyc=%0d grantOut=%h valid=%b want 0000/0", c, bus.grantOut, bus.grantValid);
      else passed++;
    end
  endtask

  task automatic test_single_grant_hold();
    do_reset();
    bus.reqIn = 16'h0010;
    tick();
    total++;
    if (bus.grantOut !== 16'h0010 || bus.grantValid !== 1'b1)
      $display("FAIL first_grant: grantOut=%h valid=%b want 0010/1", bus.grantOut, bus.grantValid);
    else passed++;
    bus.reqIn = 16'h0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (bus.grantOut !== 16'h0010 || bus.grantValid !== 1'b1)
        $display("FAIL grant_hold: cyc=%0d grantOut=%h valid=%b want 0010/1", c, bus.grantOut, bus.grantValid);
      else passed++;
    end
    bus.grantAck = 1'b1;
    tick();
    bus.grantAck = 1'b0;
    total++;
    if (bus.grantOut !== 16'h0001 || bus.grantValid !== 1'b1)
      $display("FAIL ack_handover: grantOut=%h valid=%b want 0001/1", bus.grantOut, bus.grantValid);
    else passed++;
  endtask

  task automatic test_full_rotation();
    int served [N];
    for (int i = 0; i < N; i++) served[i] = 0;
    do_reset();
    bus.reqIn    = 16'hFFFF;
    bus.grantAck = 1'b1;
    for (int k = 0; k < 2 * N + 1; k++) begin
      logic [N-1:0] want;
      tick();
      want = '0;
      want[k % N] = 1'b1;
      if (k < N) begin
        for (int i = 0; i < N; i++) if (bus.grantOut[i]) served[i]++;
      end
      total++;
      if (bus.grantOut !== want || bus.grantValid !== 1'b1)
        $display("FAIL rotation: step=%0d grantOut=%h valid=%b want %h/1", k, bus.grantOut, bus.grantValid, want);
      else passed++;
    end
    bus.grantAck = 1'b0;
    for (int i = 0; i < N; i++) begin
      total++;
      if (served[i] != 1)
        $display("FAIL rotation_fair: requester=%0d served=%0d want 1", i, served[i]);
      else passed++;
    end
  endtask

  task automatic test_fairness_skip();
    do_reset();
    bus.reqIn = 16'h0008;
    tick();
    total++;
    if (bus.grantOut !== 16'h0008)
      $display("FAIL skip_setup: grantOut=%h want 0008", bus.grantOut);
    else passed++;
    bus.reqIn    = 16'h0009;
    bus.grantAck = 1'b1;
    tick();
    total++;
    if (bus.grantOut !== 16'h0001 || bus.grantValid !== 1'b1)
      $display("FAIL skip_wrap: grantOut=%h valid=%b want 0001/1", bus.grantOut, bus.grantValid);
    else passed++;
    tick();
    bus.grantAck = 1'b0;
    total++;
    if (bus.grantOut !== 16'h0008 || bus.grantValid !== 1'b1)
      $display("FAIL skip_return: grantOut=%h valid=%b want 0008/1", bus.grantOut, bus.grantValid);
    else passed++;
  endtask

  task automatic test_ack_nothing_pending();
    do_reset();
    bus.reqIn = 16'h0100;
    tick();
    total++;
    if (bus.grantOut !== 16'h0100)
      $display("FAIL empty_setup: grantOut=%h want 0100", bus.grantOut);
    else passed++;
    bus.reqIn    = '0;
    bus.grantAck = 1'b1;
    tick();
    total++;
    if (bus.grantOut !== 16'h0000 || bus.grantValid !== 1'b0)
      $display("FAIL ack_to_idle: grantOut=%h valid=%b want 0000/0", bus.grantOut, bus.grantValid);
    else passed++;
    // Stray acknowledges while idle must leave the pointer at 9.
    repeat (3) tick();
    bus.grantAck = 1'b0;
    bus.reqIn    = 16'h0101;
    tick();
    total++;
    if (bus.grantOut !== 16'h0001 || bus.grantValid !== 1'b1)
      $display("FAIL ptr_wrap_after_idle: grantOut=%h valid=%b want 0001/1", bus.grantOut, bus.grantValid);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.reqIn = 16'h0400;
    tick();
    total++;
    if (bus.grantOut !== 16'h0400 || bus.grantValid !== 1'b1)
      $display("FAIL async_setup: grantOut=%h valid=%b want 0400/1", bus.grantOut, bus.grantValid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.grantOut !== 16'h0000 || bus.grantValid !== 1'b0)
      $display("FAIL async_clear: grantOut=%h valid=%b want 0000/0", bus.grantOut, bus.grantValid);
    else passed++;
    @(negedge clk);
    m_gidx    = -1;
    m_ptr     = 0;
    bus.reqIn = 16'h8001;
    rst_n     = 1'b1;
    tick();
    total++;
    if (bus.grantOut !== 16'h0001 || bus.grantValid !== 1'b1)
      $display("FAIL async_restart: grantOut=%h valid=%b want 0001/1", bus.grantOut, bus.grantValid);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] req;
      req = N'($urandom);
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = req & N'($urandom) & N'($urandom);
        default: ;
      endcase
      bus.reqIn    = req;
      bus.grantAck = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (bus.grantOut !== model_grant() || bus.grantValid !== (m_gidx >= 0))
        $display("FAIL random: cyc=%0d req=%h grantOut=%h valid=%b want %h/%b",
                 c, req, bus.grantOut, bus.grantValid, model_grant(), (m_gidx >= 0));
      else passed++;
    end
    bus.reqIn    = '0;
    bus.grantAck = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.reqIn    = '0;
    bus.grantAck = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_grant_hold();
    test_full_rotation();
    test_fairness_skip();
    test_ack_nothing_pending();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
